// File: rtl/instr_encoder_fifo_if.sv
// Handshake bundle between the instruction producer, the encoder FIFO and the
// instruction decoder.
//   in_valid/in_ready     : producer offers {in_opcode, in_data1, in_data2}
//   out_valid/out_ready   : packed 19-bit out_instr offered to the decoder
// modport slave  : the encoder FIFO side
// modport master : the environment side (producer + consumer)
interface instr_encoder_fifo_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_opcode;
    logic [7:0]  in_data1;
    logic [7:0]  in_data2;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_instr;

    modport slave (
        input  in_valid, in_opcode, in_data1, in_data2, out_ready,
        output in_ready, out_valid, out_instr
    );

    modport master (
        output in_valid, in_opcode, in_data1, in_data2, out_ready,
        input  in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// One-hot opcode encoder feeding a small instruction FIFO.
// Packs {enc(opcode)[2:0], data1, data2} into 19-bit words, buffers up to DEPTH
// of them and issues them in order. Opcodes that are not exactly one-hot are
// dropped, flagged for one cycle and counted (saturating).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : handshake bundle (slave modport)
//   count      : FIFO occupancy 0..DEPTH
//   err_onehot : one-cycle pulse after a malformed opcode is rejected
//   err_count  : saturating count of rejected opcodes
module instr_encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_encoder_fifo_if.slave  bus,
    output logic [CNTW-1:0]      count,
    output logic                 err_onehot,
    output logic [7:0]           err_count
);
    localparam int AW = $clog2(DEPTH);

    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [2:0] enc;
    logic [3:0] ones;
    logic       well_formed;
    logic       accept;
    logic       push;
    logic       pop;
    logic       full;

    // Encode and count set bits in one pass; enc is only meaningful when
    // exactly one bit is set.
    always_comb begin
        enc  = '0;
        ones = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus.in_opcode[k]) begin
                enc  = 3'(k);
                ones = ones + 4'd1;
            end
        end
    end

    assign well_formed = (ones == 4'd1);
    assign full        = (count == CNTW'(DEPTH));

    // in_ready depends on state only, so a pop never frees a slot in the
    // same cycle it happens.
    assign bus.in_ready  = !rst && !full;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 19'h0;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && well_formed;
    assign pop    = bus.out_valid && bus.out_ready;

    // Storage is not reset; only pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enc, bus.in_data1, bus.in_data2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_onehot <= 1'b0;
            err_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase

            err_onehot <= accept && !well_formed;
            if (accept && !well_formed && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_fifo.sv
module tb_instr_encoder_fifo;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CNTW-1:0] count;
    logic            err_onehot;
    logic [7:0]      err_count;

    instr_encoder_fifo_if bus ();

    instr_encoder_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count      (count),
        .err_onehot (err_onehot),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard state: expected words in order, expected error flags.
    logic [18:0] sb [$];
    logic        exp_pulse = 1'b0;
    logic [7:0]  exp_ecnt  = 8'h0;
    logic        mon_en    = 1'b0;
    // Expected result of the stimulus currently on the bus.
    logic [18:0] cur_exp   = '0;
    logic        cur_bad   = 1'b0;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        bad;
        logic [18:0] word;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT state against the model, then apply what the next rising
    // edge will do to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic int sz = sb.size();
            chk("mon_count",      32'(count),          32'(sz));
            chk("mon_out_valid",  32'(bus.out_valid),  32'(sz != 0));
            chk("mon_out_instr",  32'(bus.out_instr),  (sz != 0) ? 32'(sb[0]) : 32'h0);
            chk("mon_in_ready",   32'(bus.in_ready),   32'(!rst && sz < DEPTH));
            chk("mon_err_onehot", 32'(err_onehot),     32'(exp_pulse));
            chk("mon_err_count",  32'(err_count),      32'(exp_ecnt));
            if (rst) begin
                sb.delete();
                exp_pulse = 1'b0;
                exp_ecnt  = 8'h0;
            end else begin
                automatic logic acc = bus.in_valid && (sz < DEPTH);
                if (sz != 0 && bus.out_ready) void'(sb.pop_front());
                if (acc && !cur_bad) sb.push_back(cur_exp);
                exp_pulse = acc && cur_bad;
                if (acc && cur_bad && exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] d1,
                         input logic [7:0] d2, input logic bad, input logic [18:0] w);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_data1  = d1;
        bus.in_data2  = d2;
        cur_bad       = bad;
        cur_exp       = w;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 19'h0);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        idle();
        for (int c = 0; c < 20 && count != 0; c++) tick();
        chk("drain_empty", 32'(count), 32'h0);
    endtask

    initial begin
        tbl[0] = '{8'h01, 8'h11, 8'h22, 1'b0, 19'h01122};
        tbl[1] = '{8'h02, 8'hFF, 8'h00, 1'b0, 19'h1FF00};
        tbl[2] = '{8'h04, 8'h00, 8'hFF, 1'b0, 19'h200FF};
        tbl[3] = '{8'h00, 8'h55, 8'h66, 1'b1, 19'h0};
        tbl[4] = '{8'h08, 8'h12, 8'h34, 1'b0, 19'h31234};
        tbl[5] = '{8'h10, 8'h56, 8'h78, 1'b0, 19'h45678};
        tbl[6] = '{8'h03, 8'h77, 8'h88, 1'b1, 19'h0};
        tbl[7] = '{8'h40, 8'h9A, 8'hBC, 1'b0, 19'h69ABC};
        tbl[8] = '{8'hFF, 8'h01, 8'h02, 1'b1, 19'h0};
        tbl[9] = '{8'h80, 8'hDE, 8'hF0, 1'b0, 19'h7DEF0};

        idle();
        bus.out_ready = 1'b0;
        rst = 1'b1;

        // Reset held two cycles.
        tick();
        mon_en = 1'b1;
        chk("rst_in_ready_low", 32'(bus.in_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
        chk("rst_count",     32'(count),         32'h0);
        chk("rst_err_count", 32'(err_count),     32'h0);
        chk("rst_out_instr", 32'(bus.out_instr), 32'h0);

        // Single encode, held under backpressure.
        drive(1'b1, 8'h20, 8'hA5, 8'h3C, 1'b0, 19'h5A53C);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            chk("single_valid", 32'(bus.out_valid), 32'h1);
            chk("single_instr", 32'(bus.out_instr), 32'h5A53C);
            chk("single_count", 32'(count),         32'h1);
            tick();
        end
        drain();

        // Table: stream with out_ready=1; each good word replaces the last.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].bad, tbl[i].word);
            tick();
            chk("tbl_err_onehot", 32'(err_onehot),    32'(tbl[i].bad));
            chk("tbl_out_instr",  32'(bus.out_instr), 32'(tbl[i].word));
        end
        drain();

        // Fill under backpressure, fifth offer refused, then drain in order.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            automatic logic [7:0] op = 8'h01;
            automatic logic [7:0] d  = 8'(i);
            op = op << i;
            drive(1'b1, op, d, ~d, 1'b0, {3'(i), d, ~d});
            tick();
        end
        chk("fill_count",    32'(count),         32'h4);
        chk("fill_in_ready", 32'(bus.in_ready),  32'h0);
        drive(1'b1, 8'h10, 8'hEE, 8'hEE, 1'b0, 19'h4EEEE);
        tick();
        chk("fill_5th_refused", 32'(count), 32'h4);
        idle();
        bus.out_ready = 1'b1;
        tick();
        chk("fill_ready_after_pop", 32'(bus.in_ready), 32'h1);
        chk("fill_second_word",     32'(bus.out_instr[18:16]), 32'h1);
        drain();

        // Malformed opcodes with one word parked in the FIFO.
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h02, 8'h42, 8'h24, 1'b0, 19'h14224);
        tick();
        begin
            automatic logic [7:0] e0 = err_count;
            drive(1'b1, 8'h00, 8'h11, 8'h11, 1'b1, 19'h0);
            tick();
            chk("bad00_pulse", 32'(err_onehot), 32'h1);
            drive(1'b1, 8'h03, 8'h22, 8'h22, 1'b1, 19'h0);
            tick();
            chk("bad03_pulse", 32'(err_onehot), 32'h1);
            idle();
            tick();
            chk("bad_pulse_end", 32'(err_onehot), 32'h0);
            chk("bad_err_count", 32'(err_count),  32'(e0 + 8'd2));
            chk("bad_count",     32'(count),      32'h1);
            chk("bad_valid",     32'(bus.out_valid), 32'h1);
        end

        // Push and pop together at count 2.
        drive(1'b1, 8'h40, 8'h33, 8'h44, 1'b0, 19'h63344);
        tick();
        drive(1'b1, 8'h80, 8'h55, 8'h66, 1'b0, 19'h75566);
        bus.out_ready = 1'b1;
        tick();
        chk("pp_count", 32'(count), 32'h2);
        chk("pp_head",  32'(bus.out_instr), 32'h63344);
        idle();
        tick();
        chk("pp_new_last", 32'(bus.out_instr), 32'h75566);
        drain();

        // Reset with three words buffered.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h04, 8'(i), 8'h00, 1'b0, {3'd2, 8'(i), 8'h00});
            tick();
        end
        chk("mid_count_pre", 32'(count), 32'h3);
        idle();
        rst = 1'b1;
        tick();
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_count",     32'(count),         32'h0);

        // Error counter saturation.
        drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 19'h0);
        for (int i = 0; i < 260; i++) tick();
        idle();
        tick();
        chk("sat_err_count", 32'(err_count), 32'hFF);
        chk("sat_count",     32'(count),     32'h0);

        @(posedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_fifo.md
Name: instr_encoder_fifo

Overview:
- Builds 19-bit instruction words for the control unit. Inputs are a one-hot opcode and two 8-bit operands.
- Compresses the one-hot opcode to a 3-bit field and packs {opcode[2:0], data1, data2}.
- Buffers packed words in a small FIFO and issues them over a valid/ready interface toward the instruction decoder.
- Rejects malformed (not exactly one-hot) opcodes and counts the rejections.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNTW, 3, width of occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  producer offers an operation this cycle
- in_ready  output  1  encoder can accept this cycle
- in_opcode  input  8  one-hot opcode; bit k selects opcode k
- in_data1  input  8  operand 1, packed into instr[15:8]
- in_data2  input  8  operand 2, packed into instr[7:0]
- out_valid  output  1  out_instr holds a valid word
- out_ready  input  1  consumer takes the word this cycle
- out_instr  output  19  {opcode[2:0], data1[7:0], data2[7:0]}
- count  output  CNTW  current FIFO occupancy, 0..DEPTH
- err_onehot  output  1  one-cycle pulse: a malformed opcode was rejected
- err_count  output  8  saturating count of rejected opcodes

Behaviour:
- Reset (rst=1 at a rising edge):
  - Read/write pointers, count, err_count and err_onehot go to 0; out_valid=0.
  - in_ready is forced 0 during any cycle with rst=1.
  - Reset mid-operation discards all buffered words; no partial word is ever issued.
- in_ready = !rst && (count != DEPTH). It is purely a function of state, not of out_ready; there is no same-cycle pass-through when full.
- Accept event: in_valid && in_ready at a rising edge.
  - Well-formed opcode (exactly one bit set): bit index k is encoded to 3 bits (0x01→0 … 0x80→7). The word is written at the write pointer and the write pointer increments, wrapping at DEPTH.
  - Malformed opcode (zero bits or more than one bit set): nothing is written, the slot is not consumed, err_onehot=1 for the next cycle only, and err_count increments, saturating at 255.
  - in_data1/in_data2 are ignored for malformed opcodes.
- Output side:
  - out_valid = (count != 0).
  - out_instr = word at the read pointer when count != 0; 19'h0 when empty.
  - Pop event: out_valid && out_ready at a rising edge. The read pointer increments, wrapping at DEPTH.
  - While out_valid && !out_ready, out_instr is held stable.
- Latency: a well-formed word accepted at edge N is visible on out_instr with out_valid=1 in the cycle after edge N. There is no combinational bypass from input to output.
- Count update:
  - +1 on a well-formed accept without a pop.
  - −1 on a pop without a well-formed accept.
  - Unchanged when both or neither occur.
  - Simultaneous push and pop at 0 < count < DEPTH keeps count and preserves FIFO order.
  - At count=DEPTH, a pop frees a slot usable from the next cycle.
- Ordering: strict FIFO; words leave in acceptance order. Rejected operations leave no gap.
- Storage contents need no reset; only pointers and flags are reset.

Test Plan:
- Reset: hold rst 2 cycles, then release → out_valid=0, in_ready=1, count=0, err_count=0, out_instr=19'h0.
- Single encode: in_opcode=8'h20, in_data1=8'hA5, in_data2=8'h3C accepted at edge N, out_ready=0 → from cycle N+1, out_valid=1, out_instr=19'h5A53C, count=1, held for 3 cycles.
- Fill/backpressure: out_ready=0, push opcodes 8'h01, 8'h02, 8'h04, 8'h08 with data1=i, data2=~i → count=4, in_ready=0, a 5th offer is not accepted. Then out_ready=1 → instr opcode fields 0, 1, 2, 3 drain in order, and in_ready returns 1 the cycle after the first pop.
- Malformed opcodes: push 8'h00 then 8'h03 → err_onehot pulses one cycle each, err_count=2, count unchanged, out_valid unchanged.
- Simultaneous push/pop: at count=2, push 8'h80 while popping → count stays 2, and the new word (opcode field 7) emerges after the two older words.
- Reset mid-operation and saturation:
  - With count=3, assert rst for 1 cycle → out_valid=0 and count=0 the next cycle.
  - Then 260 malformed pushes → err_count=255, not wrapped.
